// File: rtl/ifetch_window.sv
// Instruction fetch window: DEPTH-word line buffer refilled from memory.
// Aligned hits return in one cycle; a miss streams the whole window in first.
module ifetch_window #(
   parameter int              XLEN  = 32,
   parameter int              DEPTH = 16,
   parameter logic [XLEN-1:0] NOP   = 32'h00000013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_in,
   input  logic            pc_req,
   input  logic            flush,
   output logic [XLEN-1:0] ins_out,
   output logic            ins_valid,
   output logic            misalign,
   output logic            busy,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = XLEN - AW - 2;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   state_t          r_state;
   logic [TW-1:0]   r_tag;
   logic            r_win_valid;
   logic [AW-1:0]   r_cnt;
   logic [XLEN-1:0] r_win [DEPTH];
   logic [XLEN-1:0] r_ins_out;
   logic            r_ins_valid;
   logic            r_misalign;

   logic [AW-1:0]   w_idx;
   logic [TW-1:0]   w_tag;
   logic            w_hit;
   logic            w_last;
   logic            w_fill_wr;

   assign w_idx     = pc_in[AW+1:2];
   assign w_tag     = pc_in[XLEN-1:AW+2];
   assign w_hit     = r_win_valid && (w_tag == r_tag);
   assign w_last    = (r_cnt == AW'(DEPTH - 1));
   assign w_fill_wr = (r_state == FILL) && mem_ack && !flush && !rst;

   // Window storage carries no reset so it can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_fill_wr) begin
         r_win[r_cnt] <= mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_tag       <= '0;
         r_win_valid <= 1'b0;
         r_cnt       <= '0;
         r_ins_out   <= NOP;
         r_ins_valid <= 1'b0;
         r_misalign  <= 1'b0;
      end else begin
         r_ins_valid <= 1'b0;
         r_misalign  <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (flush) begin
                  r_win_valid <= 1'b0;
               end else if (pc_req) begin
                  if (pc_in[1:0] != 2'b00) begin
                     r_ins_out   <= NOP;
                     r_ins_valid <= 1'b1;
                     r_misalign  <= 1'b1;
                  end else if (w_hit) begin
                     r_ins_out   <= r_win[w_idx];
                     r_ins_valid <= 1'b1;
                  end else begin
                     r_tag       <= w_tag;
                     r_win_valid <= 1'b0;
                     r_cnt       <= '0;
                     r_state     <= FILL;
                  end
               end
            end
            FILL: begin
               // Requests are ignored here; the requester keeps pc_req high.
               if (flush) begin
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end else if (mem_ack) begin
                  if (w_last) begin
                     r_cnt       <= '0;
                     r_win_valid <= 1'b1;
                     r_state     <= IDLE;
                  end else begin
                     r_cnt <= r_cnt + AW'(1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ins_out   = r_ins_out;
   assign ins_valid = r_ins_valid;
   assign misalign  = r_misalign;
   assign busy      = (r_state == FILL);
   assign mem_req   = (r_state == FILL);
   assign mem_addr  = mem_req ? {r_tag, r_cnt, 2'b00} : '0;

endmodule

// File: tb/tb_ifetch_window.sv
// Scoreboard bench for ifetch_window: expected words are derived from the
// address-based memory image, tagged with an epoch that changes on flush/reset.
module tb_ifetch_window;

   localparam int          XLEN  = 32;
   localparam int          DEPTH = 16;
   localparam logic [31:0] NOPV  = 32'h00000013;
   localparam int          MISS_LAT = DEPTH + 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic        pc_req;
   logic        flush;
   logic [31:0] ins_out;
   logic        ins_valid;
   logic        misalign;
   logic        busy;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   ifetch_window #(
      .XLEN (XLEN),
      .DEPTH(DEPTH),
      .NOP  (NOPV)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pc_in    (pc_in),
      .pc_req   (pc_req),
      .flush    (flush),
      .ins_out  (ins_out),
      .ins_valid(ins_valid),
      .misalign (misalign),
      .busy     (busy),
      .mem_req  (mem_req),
      .mem_addr (mem_addr),
      .mem_ack  (mem_ack),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int epoch = 0;
   int ack_mode = 0;
   int fill_acks = 0;
   int stall_n = 0;

   logic [31:0] q_ins [$];
   bit          q_mis [$];

   // Memory image: word at byte address a; epoch makes stale data visible.
   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (32'h1000 + (a >> 2) - 32'h10) ^ (32'(epoch) << 16);
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory responder: 0 = always ack, 1 = random stalls,
   // 2 = withhold ack for 3 cycles once two words have been delivered.
   always @(negedge clk) begin
      if (mem_req) begin
         if (ack_mode == 2 && fill_acks == 2 && stall_n < 3) begin
            mem_ack = 1'b0;
            stall_n++;
            chk("stall_addr", mem_addr, 32'h48);
         end else if (ack_mode == 1 && $urandom_range(0, 3) == 0) begin
            mem_ack = 1'b0;
         end else begin
            mem_ack = 1'b1;
         end
         mem_rdata = mem_fn(mem_addr);
         if (mem_ack) fill_acks++;
      end else begin
         mem_ack   = 1'b0;
         fill_acks = 0;
         stall_n   = 0;
      end
   end

   // Monitor: every presented instruction is matched against the scoreboard.
   always @(negedge clk) begin
      if (!rst && ins_valid) begin
         if (q_ins.size() == 0) begin
            chk("unexpected_ins_valid", {31'b0, ins_valid}, 32'h0);
         end else begin
            logic [31:0] e;
            bit          m;
            e = q_ins.pop_front();
            m = q_mis.pop_front();
            chk("ins_out", ins_out, e);
            chk("misalign", {31'b0, misalign}, {31'b0, m});
         end
      end
      if (!rst && misalign && !ins_valid) begin
         chk("misalign_without_valid", {31'b0, ins_valid}, 32'h1);
      end
   end

   task automatic do_req(input logic [31:0] pc, output int lat);
      bit          m;
      logic [31:0] e;
      m = (pc[1:0] != 2'b00);
      e = m ? NOPV : mem_fn(pc);
      q_ins.push_back(e);
      q_mis.push_back(m);
      pc_in  = pc;
      pc_req = 1'b1;
      lat    = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ins_valid && lat < 400);
      if (!ins_valid) chk("req_timeout", {31'b0, ins_valid}, 32'h1);
      pc_req = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      epoch++;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ins_out"}, ins_out, NOPV);
      chk({tag, "_ins_valid"}, {31'b0, ins_valid}, 32'h0);
      chk({tag, "_misalign"}, {31'b0, misalign}, 32'h0);
      chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
      chk({tag, "_mem_req"}, {31'b0, mem_req}, 32'h0);
      chk({tag, "_mem_addr"}, mem_addr, 32'h0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [31:0] bases [4];
      logic [31:0] pc;
      logic [31:0] m_base;
      bit          m_valid;

      bases[0] = 32'h0000_0040;
      bases[1] = 32'h0000_1000;
      bases[2] = 32'h0000_ABC0;
      bases[3] = 32'h7FFF_FFC0;

      rst = 1'b1; pc_req = 1'b0; flush = 1'b0; pc_in = '0;
      repeat (3) @(negedge clk);
      chk_reset_outs("reset");
      rst = 1'b0;

      // Cold miss at 0x40 with zero-wait memory.
      q_ins.push_back(mem_fn(32'h40));
      q_mis.push_back(1'b0);
      pc_in  = 32'h40;
      pc_req = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         chk("fill_busy", {31'b0, busy}, 32'h1);
         chk("fill_addr", mem_addr, 32'h40 + 32'(4 * i));
      end
      @(negedge clk);
      chk("fill_done_busy", {31'b0, busy}, 32'h0);
      chk("fill_done_memreq", {31'b0, mem_req}, 32'h0);
      chk("fill_done_novalid", {31'b0, ins_valid}, 32'h0);
      @(negedge clk);
      chk("miss_valid", {31'b0, ins_valid}, 32'h1);
      chk("first_word", ins_out, 32'h1000);
      pc_req = 1'b0;

      // Back-to-back hits.
      do_req(32'h48, lat); chk("b2b_lat0", lat, 1); chk("b2b_memreq0", {31'b0, mem_req}, 0);
      do_req(32'h7C, lat); chk("b2b_lat1", lat, 1); chk("b2b_memreq1", {31'b0, mem_req}, 0);
      do_req(32'h44, lat); chk("b2b_lat2", lat, 1); chk("b2b_memreq2", {31'b0, mem_req}, 0);

      // Misaligned request.
      do_req(32'h42, lat);
      chk("mis_lat", lat, 1);
      chk("mis_memreq", {31'b0, mem_req}, 0);
      @(negedge clk);
      chk("mis_memreq_after", {31'b0, mem_req}, 0);

      // Flush in IDLE blocks the same-cycle request and invalidates.
      flush = 1'b1; pc_in = 32'h40; pc_req = 1'b1;
      @(negedge clk);
      chk("flush_idle_novalid", {31'b0, ins_valid}, 32'h0);
      flush = 1'b0; pc_req = 1'b0; epoch++;
      do_req(32'h40, lat);
      chk("flush_idle_miss_lat", lat, MISS_LAT);

      // Flush mid-fill at counter 5.
      do_flush();
      pc_in = 32'h40; pc_req = 1'b1;
      @(negedge clk);
      pc_req = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_addr", mem_addr, 32'h54);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("abort_busy", {31'b0, busy}, 32'h0);
      chk("abort_memreq", {31'b0, mem_req}, 32'h0);
      epoch++;
      do_req(32'h40, lat);
      chk("abort_refill_lat", lat, MISS_LAT);

      // Withheld acks at counter 2.
      do_flush();
      ack_mode = 2;
      do_req(32'h48, lat);
      chk("stall_lat", lat, MISS_LAT + 3);
      ack_mode = 0;

      // Reset mid-fill.
      do_flush();
      pc_in = 32'h48; pc_req = 1'b1;
      @(negedge clk);
      pc_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outs("rst_fill");
      rst = 1'b0;
      epoch++;
      do_req(32'h48, lat);
      chk("rst_refill_lat", lat, MISS_LAT);

      // Randomized traffic against the window-level model.
      ack_mode = 1;
      do_flush();
      m_valid = 1'b0;
      m_base  = '0;
      for (int it = 0; it < 150; it++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0) begin
            do_flush();
            m_valid = 1'b0;
         end else if (r == 1) begin
            @(negedge clk);
         end else begin
            pc = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, DEPTH - 1) * 4);
            if ($urandom_range(0, 7) == 0) pc = pc + 32'($urandom_range(1, 3));
            do_req(pc, lat);
            if (pc[1:0] != 2'b00) begin
               chk("rnd_mis_lat", lat, 1);
            end else if (m_valid && m_base == {pc[31:6], 6'b0}) begin
               chk("rnd_hit_lat", lat, 1);
            end else begin
               chk("rnd_miss_lat", {31'b0, lat >= MISS_LAT}, 32'h1);
               m_valid = 1'b1;
               m_base  = {pc[31:6], 6'b0};
            end
         end
      end

      repeat (3) @(negedge clk);
      chk("queue_empty", q_ins.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
